// File: rtl/rv_gpio_ctrl.sv
// Memory-mapped GPIO bank: synchronised inputs with rising-edge capture, maskable level IRQ, registered outputs.
// Optional per-bit input debounce is built when GPIO_DEBOUNCE_EN is defined.
module rv_gpio_ctrl #(
  parameter int unsigned      WIDTH           = 16,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0,
  parameter int unsigned      DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    REG_DATA_IN  = 2'd0,
    REG_DATA_OUT = 2'd1,
    REG_IRQ_EN   = 2'd2,
    REG_IRQ_STAT = 2'd3
  } reg_addr_e;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("rv_gpio_ctrl: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rv_gpio_ctrl: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("rv_gpio_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end

  reg_addr_e                        addr;
  logic [WIDTH-1:0]                 wdata_w;
  logic                             unused_wdata;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                 sync_in;
  logic [WIDTH-1:0]                 stable;
  logic [WIDTH-1:0]                 prev_q;
  logic [WIDTH-1:0]                 rise;
  logic [WIDTH-1:0]                 data_out_q;
  logic [WIDTH-1:0]                 irq_en_q;
  logic [WIDTH-1:0]                 irq_stat_q;
  logic [WIDTH-1:0]                 w1c;
  logic [31:0]                      rd_mux;

  assign addr         = reg_addr_e'(i_addr);
  assign wdata_w      = i_wdata[WIDTH-1:0];
  assign unused_wdata = ^i_wdata;

  // Input synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i_data;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0][CW-1:0] db_cnt;
  logic [WIDTH-1:0]         stable_q;

  // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      stable_q <= '0;
    end else begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (sync_in[b] == stable_q[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[b] <= sync_in[b];
          db_cnt[b]   <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + CW'(1);
        end
      end
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync_in;
`endif

  assign rise = stable & ~prev_q;
  assign w1c  = (i_sel && i_we && addr == REG_IRQ_STAT) ? wdata_w : '0;

  // Rise is OR-ed in after the clear, so a same-cycle edge survives a W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      irq_stat_q <= '0;
    end else begin
      prev_q     <= stable;
      irq_stat_q <= (irq_stat_q & ~w1c) | rise;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      REG_DATA_IN:  rd_mux = 32'(stable);
      REG_DATA_OUT: rd_mux = 32'(data_out_q);
      REG_IRQ_EN:   rd_mux = 32'(irq_en_q);
      REG_IRQ_STAT: rd_mux = 32'(irq_stat_q);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= RESET_OUT;
      irq_en_q   <= '0;
      o_rdata    <= '0;
      o_ready    <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      o_ready <= i_sel;
      o_irq   <= |(irq_stat_q & irq_en_q);
      if (i_sel) begin
        o_rdata <= i_we ? '0 : rd_mux;
        if (i_we) begin
          case (addr)
            REG_DATA_OUT: data_out_q <= wdata_w;
            REG_IRQ_EN:   irq_en_q   <= wdata_w;
            default:      ;
          endcase
        end
      end
    end
  end

  assign o_data = data_out_q;

endmodule

// File: doc/rv_gpio_ctrl.md
Name: rv_gpio_ctrl

Overview:
Parametrised memory-mapped GPIO controller; successor to the fixed 16-bit switch/LED path of the SoC wrapper.
- Synchronises a WIDTH-bit input bank and detects rising edges on it, with optional debounce.
- Raises a maskable level interrupt.
- Drives a registered WIDTH-bit output bank.
- Sits on the SoC peripheral bus beside the UART and is instantiated once per GPIO bank.

Parameters:
- WIDTH, 16, number of input and output pins (1..32).
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).
- RESET_OUT, 0, reset value of the output register (WIDTH bits).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before an input change is accepted (only used with GPIO_DEBOUNCE_EN; >=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_sel  in  1  bus access strobe, one cycle per access.
- i_we  in  1  1 = write, 0 = read; sampled with i_sel.
- i_addr  in  2  word index: 0 DATA_IN, 1 DATA_OUT, 2 IRQ_EN, 3 IRQ_STAT.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid while o_ready=1.
- o_ready  out  1  access-complete pulse.
- i_data  in  WIDTH  asynchronous external input pins.
- o_data  out  WIDTH  registered output pins.
- o_irq  out  1  interrupt, level, active-high.

Behaviour:
- Reset: all outputs and state take these values asynchronously while reset=0.
  - o_data=RESET_OUT, o_rdata=0, o_ready=0, o_irq=0.
  - Synchroniser chains, stable register, edge-history register, IRQ_EN and IRQ_STAT all 0.
- Input path:
  - Each i_data bit passes through SYNC_STAGES flops, giving sync_in.
  - stable = sync_in (or the debounced value, see Optional Feature).
  - Latency from i_data change to a DATA_IN read: SYNC_STAGES cycles without debounce.
- Edge detect:
  - prev <= stable every cycle.
  - rise = stable & ~prev, which sets the corresponding IRQ_STAT bit.
  - Because prev resets to 0, a pin held high through reset release records one rising edge once it propagates. This is intended; firmware clears IRQ_STAT at init.
- Bus protocol:
  - An access is accepted in a cycle with i_sel=1.
  - o_ready=1 exactly one cycle later, for one cycle.
  - o_rdata is registered in the acceptance cycle and held until the next access. It reads 0 for writes.
  - Back-to-back i_sel on consecutive cycles is legal; each access gets its own o_ready.
- Register map:
  - DATA_IN (0): read-only, returns stable; writes ignored.
  - DATA_OUT (1): read/write. A write updates o_data on the next clock edge. Reads return the register value.
  - IRQ_EN (2): read/write mask.
  - IRQ_STAT (3): write-1-to-clear. Reads return sticky rise bits.
- Width rules: write bits [31:WIDTH] are ignored; reads are zero-extended to 32 bits.
- Simultaneous rise and W1C on the same bit in the same cycle: set wins and the bit stays 1.
- Interrupt: o_irq registered, o_irq <= |(IRQ_STAT & IRQ_EN), i.e. one cycle after the status/enable change.
- Mid-operation reset:
  - An access accepted in the cycle reset asserts produces no o_ready.
  - Debounce counters and pending edges are discarded.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever sync_in equals stable.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, stable takes sync_in and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable or IRQ_STAT.
  - Latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Undefined: no counters are built and stable = sync_in.

Test Plan:
- Reset release with i_data=0, RESET_OUT=16'h00A5 -> o_data=0x00A5, o_irq=0; reads of all four registers return 0 except DATA_OUT=0x000000A5.
- Write DATA_OUT 0xFFFF1234 (WIDTH=16) -> o_data=0x1234 one cycle after acceptance; read back returns 0x00001234 with o_ready one cycle after i_sel.
- Write IRQ_EN=0x0001, then pulse i_data[0] low->high -> IRQ_STAT=0x0001 after SYNC_STAGES+1 cycles, o_irq=1 the following cycle; W1C 0x0001 -> o_irq=0 next cycle.
- Schedule the W1C of bit 0 in the same cycle a new rise on bit 0 is detected -> IRQ_STAT bit 0 remains 1 and o_irq stays high.
- With GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle high glitch on i_data[3] -> DATA_IN stays 0 and no IRQ_STAT bit set; 6-cycle high -> DATA_IN bit 3=1 and IRQ_STAT=0x0008.
- Assert reset during an accepted write to DATA_OUT -> no o_ready pulse; o_data=RESET_OUT after release.
